ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//   Shares one port (port A) of the banked dual-port RAM between two requesters (m0, m1).
//   Round-robin arbitration with optional lock bursts, capped at MAX_HOLD granted cycles per burst.
//   Muxes the winner's command onto the RAM port and returns read data to the winner one cycle later.
//   Sits between the two bus-side masters and the RAM top-level port A.
// PARAMETERS
//   ADDR_WIDTH  5  RAM word address width (bank select + row)
//   DATA_WIDTH  8  RAM data width
//   MAX_HOLD    4  max consecutive grants per lock burst (>=1); counter width $clog2(MAX_HOLD+1)
// PORTS
//   clka        in   1           clock, shared with RAM port A
//   rsta        in   1           synchronous active-high reset
//   m0_req      in   1           m0 command valid
//   m0_we       in   1           m0 write (1) / read (0)
//   m0_lock     in   1           m0 requests to keep the port after this grant
//   m0_addr     in   ADDR_WIDTH  m0 address
//   m0_wdata    in   DATA_WIDTH  m0 write data
//   m0_gnt      out  1           m0 command accepted this cycle (combinational)
//   m0_rvalid   out  1           m0 read data valid (registered)
//   m0_rdata    out  DATA_WIDTH  m0 read data; meaningful only while m0_rvalid
//   m1_*        same set as m0_* for requester 1
//   ram_en      out  1           to RAM ena
//   ram_we      out  1           to RAM wea
//   ram_addr    out  ADDR_WIDTH  to RAM addra
//   ram_din     out  DATA_WIDTH  to RAM dina
//   ram_dout    in   DATA_WIDTH  from RAM douta; valid 1 cycle after a read enable
// BEHAVIOUR
//   - Handshake: mX holds req/we/lock/addr/wdata stable until mX_gnt=1. A command transfers in the
//     cycle req & gnt are both 1. At most one gnt per cycle. gnt never asserts without req.
//   - RAM port: ram_en = m0_gnt | m1_gnt, and ram_we/addr/din come from the granted requester, all
//     combinational. With no grant: ram_en=0, ram_we=0, addr=0, din=0.
//   - Read return: a read granted in cycle N gives mX_rvalid=1 in cycle N+1 and mX_rdata=ram_dout.
//     Writes never produce rvalid. Back-to-back reads are fully pipelined, one per cycle.
//   - State: last (1 bit, last winner), st in {ARB, HOLD0, HOLD1}, hold_cnt.
//   - ARB: only one req -> it wins. Both req -> the one with index != last wins. None -> no grant.
//     On a win by w: last<=w. If mw_lock=1 and MAX_HOLD>1, go to HOLDw with hold_cnt<=1.
//   - HOLDw: only mw can be granted; the other requester waits even if mw_req=0.
//     On each grant hold_cnt++. Go to ARB when mw_req=0, or mw_lock=0, or hold_cnt reaches MAX_HOLD.
//     The ARB exit uses last=w, so the other requester wins the next tie.
//   - Idle in HOLDw (mw_req=0): no grant that cycle, return to ARB next cycle.
//   - MAX_HOLD=1: lock is ignored and state stays ARB.
//   - Reset (rsta=1 at a clka edge): st<=ARB, last<=1 (m0 wins the first tie), hold_cnt<=0,
//     m0_rvalid/m1_rvalid<=0. While rsta=1, both gnt=0 and ram_en=0.
//     Reset mid-operation discards any in-flight read return: no rvalid in the cycle after reset.
//   - Address/bank decode is not done here; the full ADDR_WIDTH address is passed through unchanged.
// TESTING
//   1. Reset, then m0 read addr 5'h09 alone -> m0_gnt same cycle; next cycle m0_rvalid=1,
//      m0_rdata=previous write to 0x09; m1_rvalid=0.
//   2. Both req every cycle, lock=0 -> grants alternate m0,m1,m0,m1 (m0 first after reset).
//      Each read returns to its own master with 1-cycle latency.
//   3. m0 lock=1 with 6 writes queued, m1 req held, MAX_HOLD=4 -> m0 granted 4 consecutive
//      cycles, then m1 granted, then m0.
//   4. m0 write 0xA5 to 0x1F granted, then m1 read 0x1F next cycle -> m1_rdata=0xA5, m0_rvalid
//      stays 0; also writes to 0x00/0x08/0x10/0x18 read back distinct values (bank walk).
//   5. Assert rsta for 1 cycle while a read is in flight and m1 is in HOLD1 -> no rvalid after
//      reset, no gnt during reset, st=ARB; next both-req tie goes to m0.
//   6. Random stimulus with a scoreboard: gnt onehot0, gnt implies req, rvalid only after a
//      granted read, and no requester starved beyond MAX_HOLD+1 cycles.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares port A of the banked dual-port RAM between two requesters (m0, m1).
//   Arbitration is round-robin. A winner may lock the port for a burst of up to
//   MAX_HOLD consecutive grants. The winner's command is muxed onto the RAM port.
//   Read data comes back to the winner one cycle after its read was granted.
//
// Ports
//   clka, rsta               clock shared with RAM port A; synchronous active-high reset
//   mX_req/we/lock/addr/wdata command from requester X, held stable until mX_gnt
//   mX_gnt                   command accepted this cycle (combinational)
//   mX_rvalid, mX_rdata      read return, one cycle after a granted read
//   ram_en/we/addr/din       command to RAM port A (combinational mux of the winner)
//   ram_dout                 RAM read data, valid one cycle after a read enable
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int   CNT_W   = $clog2(MAX_HOLD + 1);
  // A burst of one grant is no burst at all, so lock has no effect then.
  localparam logic LOCK_EN = (MAX_HOLD > 1);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_HOLD0 = 2'd1,
    ST_HOLD1 = 2'd2
  } st_t;

  st_t              r_st, w_st_nxt;
  logic             r_last, w_last_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic             w_gnt0, w_gnt1;
  logic             w_any_gnt;
  logic             w_lock_win;
  logic             r_rvalid0, r_rvalid1;

  // State register
  always_ff @(posedge clka) begin
    if (rsta) begin
      r_st       <= ST_ARB;
      r_last     <= 1'b1;          // m0 wins the first tie
      r_hold_cnt <= '0;
    end else begin
      r_st       <= w_st_nxt;
      r_last     <= w_last_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // Grant decode (output logic of the FSM); no grant at all while in reset
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rsta) begin
      case (r_st)
        ST_ARB: begin
          if (m0_req && m1_req) begin
            // Tie goes to the requester that did not win last time
            w_gnt0 = r_last;
            w_gnt1 = !r_last;
          end else begin
            w_gnt0 = m0_req;
            w_gnt1 = m1_req;
          end
        end
        // The holder owns the port; the other side waits even if the holder is idle
        ST_HOLD0: w_gnt0 = m0_req;
        ST_HOLD1: w_gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  assign w_any_gnt  = w_gnt0 | w_gnt1;
  assign w_lock_win = w_gnt0 ? m0_lock : m1_lock;

  // Next-state logic
  always_comb begin
    w_st_nxt       = r_st;
    w_last_nxt     = r_last;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_st)
      ST_ARB: begin
        if (w_any_gnt) begin
          w_last_nxt = w_gnt1;
          if (w_lock_win && LOCK_EN) begin
            w_st_nxt       = w_gnt1 ? ST_HOLD1 : ST_HOLD0;
            w_hold_cnt_nxt = CNT_W'(1);
          end
        end
      end
      ST_HOLD0, ST_HOLD1: begin
        // r_last already names the holder, so leaving hands the next tie to the other side
        if (!w_any_gnt || !w_lock_win || (r_hold_cnt == CNT_W'(MAX_HOLD - 1))) begin
          w_st_nxt       = ST_ARB;
          w_hold_cnt_nxt = '0;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_st_nxt       = ST_ARB;
        w_hold_cnt_nxt = '0;
      end
    endcase
  end

  // Read-return tracking; reset drops any pending return
  always_ff @(posedge clka) begin
    if (rsta) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~m0_we;
      r_rvalid1 <= w_gnt1 & ~m1_we;
    end
  end

  // RAM command mux, zeroed when nobody is granted
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (w_gnt0) begin
      ram_we   = m0_we;
      ram_addr = m0_addr;
      ram_din  = m0_wdata;
    end else if (w_gnt1) begin
      ram_we   = m1_we;
      ram_addr = m1_addr;
      ram_din  = m1_wdata;
    end
  end

  assign ram_en    = w_any_gnt;
  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Drives two requesters from command queues, models the RAM behind port A,
//   predicts grants from the arbitration rules and checks read returns through
//   a scoreboard consumed by an independent monitor.
module tb_ram_port_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int MH    = 4;
  localparam int LIMIT = MH + 1;
  localparam int DEPTH = 1 << AW;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic          rsta = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
    .clka(clka), .rsta(rsta),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Single-port synchronous RAM behind port A
  logic [DW-1:0] ram_mem [0:DEPTH-1];
  always @(posedge clka) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      else        ram_dout <= ram_mem[ram_addr];
    end
  end

  typedef struct packed {
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic          m;
    logic [DW-1:0] data;
    logic [31:0]   due;
  } exp_t;

  cmd_t          q0[$], q1[$];
  exp_t          sb[$];
  exp_t          e_mon;
  logic [DW-1:0] shadow [0:DEPTH-1];
  int            n_tests = 0, n_fail = 0;
  int            cyc = 0;
  bit            rst_drv = 1'b1;
  bit            mon_en = 1'b0;
  int            glog[$];
  // Reference model: who won last, who currently owns a burst, how long it has run
  bit            m_last = 1'b1;
  int            m_owner = -1;
  int            m_burst = 0;
  int            wait0 = 0, wait1 = 0;
  int            rv0_cnt = 0, rv1_cnt = 0;
  logic [DW-1:0] last_rd0 = '0, last_rd1 = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(input logic we, input logic lock, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
    cmd_t c;
    c.we = we; c.lock = lock; c.addr = a; c.wdata = d;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
              AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 255)));
  endfunction

  // One clock cycle: present queue heads, predict and check the grant, update the model
  task automatic step();
    cmd_t c0, c1, cg;
    bit   r0, r1;
    int   g;
    @(posedge clka);
    cyc++;
    #1;
    r0 = (q0.size() > 0);
    r1 = (q1.size() > 0);
    c0 = r0 ? q0[0] : rand_cmd();
    c1 = r1 ? q1[0] : rand_cmd();
    rsta = rst_drv;
    m0_req = r0; m0_we = c0.we; m0_lock = c0.lock; m0_addr = c0.addr; m0_wdata = c0.wdata;
    m1_req = r1; m1_we = c1.we; m1_lock = c1.lock; m1_addr = c1.addr; m1_wdata = c1.wdata;
    #1;
    g = -1;
    if (!rst_drv) begin
      if (m_owner >= 0) begin
        if ((m_owner == 0 && r0) || (m_owner == 1 && r1)) g = m_owner;
      end else if (r0 && r1) g = m_last ? 0 : 1;
      else if (r0) g = 0;
      else if (r1) g = 1;
    end
    cg = (g == 0) ? c0 : (g == 1) ? c1 : '0;
    chk("m0_gnt", 32'(m0_gnt), 32'(g == 0));
    chk("m1_gnt", 32'(m1_gnt), 32'(g == 1));
    chk("ram_en", 32'(ram_en), 32'(g >= 0));
    chk("ram_we", 32'(ram_we), 32'(cg.we));
    chk("ram_addr", 32'(ram_addr), 32'(cg.addr));
    chk("ram_din", 32'(ram_din), 32'(cg.wdata));
    chk("gnt_onehot0", 32'(m0_gnt & m1_gnt), 32'd0);
    chk("gnt_implies_req", 32'((m0_gnt & ~m0_req) | (m1_gnt & ~m1_req)), 32'd0);
    if (rst_drv) begin
      m_last = 1'b1; m_owner = -1; m_burst = 0; wait0 = 0; wait1 = 0;
    end else begin
      if (r0 && g != 0) wait0++;
      if (r1 && g != 1) wait1++;
      if (g == 0) begin chk("m0_wait_bound", 32'(wait0 <= LIMIT), 32'd1); wait0 = 0; end
      if (g == 1) begin chk("m1_wait_bound", 32'(wait1 <= LIMIT), 32'd1); wait1 = 0; end
      if (g >= 0) begin
        glog.push_back(g);
        if (g == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        if (cg.we) shadow[cg.addr] = cg.wdata;
        else       sb.push_back('{m: g[0], data: shadow[cg.addr], due: 32'(cyc + 1)});
      end
      if (m_owner >= 0) begin
        if (g < 0) m_owner = -1;
        else begin
          m_burst++;
          if (!cg.lock || m_burst >= MH) m_owner = -1;
        end
      end else if (g >= 0) begin
        m_last = g[0];
        if (cg.lock && MH > 1) begin m_owner = g; m_burst = 1; end
      end
    end
  endtask

  // Read-return monitor
  always @(negedge clka) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == 32'(cyc)) begin
        e_mon = sb.pop_front();
        chk("m0_rvalid", 32'(m0_rvalid), 32'(e_mon.m == 1'b0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(e_mon.m == 1'b1));
        if (e_mon.m) chk("m1_rdata", 32'(m1_rdata), 32'(e_mon.data));
        else         chk("m0_rdata", 32'(m0_rdata), 32'(e_mon.data));
      end else begin
        chk("m0_rvalid_idle", 32'(m0_rvalid), 32'd0);
        chk("m1_rvalid_idle", 32'(m1_rvalid), 32'd0);
      end
      if (m0_rvalid === 1'b1) begin rv0_cnt++; last_rd0 = m0_rdata; end
      if (m1_rvalid === 1'b1) begin rv1_cnt++; last_rd1 = m1_rdata; end
    end
  end

  task automatic do_reset();
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    glog.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && (q0.size() > 0 || q1.size() > 0); i++) step();
    chk("drain_done", 32'(q0.size() + q1.size()), 32'd0);
    step();
    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_log(input string nm, input int e[$]);
    chk({nm, "_len"}, 32'(glog.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < glog.size(); i++) chk(nm, 32'(glog[i]), 32'(e[i]));
  endtask

  initial begin
    int ev[$];
    int rv0_s, rv1_s;
    step();
    step();
    rst_drv = 1'b0;
    mon_en  = 1'b1;
    // Reset state: idle port, no returns
    step();
    chk("reset_idle_en", 32'(ram_en | m0_gnt | m1_gnt), 32'd0);
    chk("reset_idle_rvalid", 32'(m0_rvalid | m1_rvalid), 32'd0);

    // Fill the whole RAM so every later read has a known expected value
    for (int a = 0; a < DEPTH; a++) q0.push_back(mk(1'b1, 1'b0, AW'(a), DW'($urandom_range(0, 255))));
    drain();

    // Single read by m0
    do_reset();
    rv1_s = rv1_cnt;
    q0.push_back(mk(1'b1, 1'b0, 5'h09, 8'h3C));
    q0.push_back(mk(1'b0, 1'b0, 5'h09, 8'h00));
    drain();
    chk("t1_rdata", 32'(last_rd0), 32'h3C);
    chk("t1_m1_quiet", 32'(rv1_cnt - rv1_s), 32'd0);

    // Alternating grants with no lock
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 1'b0, AW'($urandom_range(0, DEPTH - 1)), 8'h00));
      q1.push_back(mk(1'b0, 1'b0, AW'($urandom_range(0, DEPTH - 1)), 8'h00));
    end
    drain();
    ev = '{0, 1, 0, 1, 0, 1, 0, 1};
    chk_log("t2_order", ev);

    // Locked burst capped at MAX_HOLD
    do_reset();
    for (int i = 0; i < 6; i++) q0.push_back(mk(1'b1, 1'b1, AW'(i), DW'(8'h60 + i)));
    q1.push_back(mk(1'b0, 1'b0, 5'h03, 8'h00));
    drain();
    ev = '{0, 0, 0, 0, 1, 0, 0};
    chk_log("t3_order", ev);

    // Write by m0 then read by m1, then a bank walk
    do_reset();
    rv0_s = rv0_cnt;
    q0.push_back(mk(1'b1, 1'b0, 5'h1F, 8'hA5));
    q1.push_back(mk(1'b0, 1'b0, 5'h1F, 8'h00));
    drain();
    chk("t4_rdata", 32'(last_rd1), 32'hA5);
    chk("t4_m0_quiet", 32'(rv0_cnt - rv0_s), 32'd0);
    for (int i = 0; i < 4; i++) q0.push_back(mk(1'b1, 1'b0, AW'(8 * i), DW'(8'h11 * (i + 1))));
    for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, 1'b0, AW'(8 * i), 8'h00));
    drain();
    chk("t4_bank_last", 32'(last_rd0), 32'h44);
    chk("t4_bank_cnt", 32'(rv0_cnt - rv0_s), 32'd4);

    // Reset while m1 holds the port and a read is in flight
    do_reset();
    for (int i = 0; i < 3; i++) q1.push_back(mk(1'b0, 1'b1, AW'(i + 4), 8'h00));
    step();
    q0.push_back(mk(1'b0, 1'b0, 5'h0A, 8'h00));
    step();
    rst_drv = 1'b1;
    step();
    chk("t5_no_gnt_in_reset", 32'(m0_gnt | m1_gnt | ram_en), 32'd0);
    rst_drv = 1'b0;
    glog.delete();
    step();
    chk("t5_no_rvalid_after_reset", 32'(m0_rvalid | m1_rvalid), 32'd0);
    drain();
    ev = '{0, 1};
    chk_log("t5_order", ev);

    // Random traffic
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 9) < 6) q0.push_back(rand_cmd());
      if (q1.size() == 0 && $urandom_range(0, 9) < 6) q1.push_back(rand_cmd());
      rst_drv = ($urandom_range(0, 299) == 0);
      step();
    end
    rst_drv = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
